// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC and fetches one instruction word at a time from imem
// over a req/ack handshake. Each word is presented downstream as {inst_out, pc_out} with
// inst_valid and is held until inst_ready. A branch redirect reloads the PC and squashes
// any held or in-flight instruction.
//
// Ports:
//   i_clk, i_rst_if       clock (rising edge), asynchronous active-high reset
//   o_imem_req/o_imem_addr  fetch request; the address is stable while the request is high
//   i_imem_ack/i_imem_rdata 1-cycle ack carrying the word for the outstanding request
//   i_branch_taken/target   1-cycle redirect from execute
//   i_inst_ready            downstream accepts the presented instruction this cycle
//   o_inst_valid/o_inst_out/o_pc_out  presented instruction and its address
//   o_addr_misalign         1-cycle pulse when a redirect target has nonzero low bits
module if_fetch_unit #(
    parameter int unsigned             BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0]    RESET_PC  = '0,
    parameter int unsigned             PC_STEP   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_if,
    output logic                 o_imem_req,
    output logic [BUS_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [BUS_WIDTH-1:0] i_imem_rdata,
    input  logic                 i_branch_taken,
    input  logic [BUS_WIDTH-1:0] i_branch_target,
    input  logic                 i_inst_ready,
    output logic                 o_inst_valid,
    output logic [BUS_WIDTH-1:0] o_inst_out,
    output logic [BUS_WIDTH-1:0] o_pc_out,
    output logic                 o_addr_misalign
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e               r_state,     w_state_d;
    logic [BUS_WIDTH-1:0] r_pc,        w_pc_d;
    logic [BUS_WIDTH-1:0] r_req_addr,  w_req_addr_d;
    logic                 r_drop,      w_drop_d;
    logic                 r_inst_valid, w_inst_valid_d;
    logic [BUS_WIDTH-1:0] r_inst_out,  w_inst_out_d;
    logic [BUS_WIDTH-1:0] r_pc_out,    w_pc_out_d;
    logic                 r_misalign,  w_misalign_d;

    logic [BUS_WIDTH-1:0] w_target_aligned;
    logic                 w_target_misaligned;

    assign w_target_aligned    = {i_branch_target[BUS_WIDTH-1:2], 2'b00};
    assign w_target_misaligned = |i_branch_target[1:0];

    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_req_addr_d   = r_req_addr;
        w_drop_d       = r_drop;
        w_inst_valid_d = r_inst_valid;
        w_inst_out_d   = r_inst_out;
        w_pc_out_d     = r_pc_out;
        w_misalign_d   = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_state_d = StFetch;
                if (i_branch_taken) begin
                    w_pc_d       = w_target_aligned;
                    w_req_addr_d = w_target_aligned;
                end else begin
                    w_req_addr_d = r_pc;
                end
            end
            StFetch: begin
                if (i_branch_taken) begin
                    w_pc_d       = w_target_aligned;
                    w_misalign_d = w_target_misaligned;
                end
                if (i_imem_ack) begin
                    if (r_drop || i_branch_taken) begin
                        // Word belongs to the pre-redirect stream: discard and refetch.
                        w_drop_d     = 1'b0;
                        w_req_addr_d = i_branch_taken ? w_target_aligned : r_pc;
                    end else begin
                        w_inst_out_d   = i_imem_rdata;
                        w_pc_out_d     = r_req_addr;
                        w_inst_valid_d = 1'b1;
                        w_pc_d         = r_pc + BUS_WIDTH'(PC_STEP);
                        w_state_d      = StHold;
                    end
                end else if (i_branch_taken) begin
                    // The outstanding transaction must still complete; mark it stale.
                    w_drop_d = 1'b1;
                end
            end
            StHold: begin
                if (i_branch_taken) begin
                    w_pc_d         = w_target_aligned;
                    w_misalign_d   = w_target_misaligned;
                    w_inst_valid_d = 1'b0;
                    w_req_addr_d   = w_target_aligned;
                    w_state_d      = StFetch;
                end else if (i_inst_ready) begin
                    w_inst_valid_d = 1'b0;
                    w_req_addr_d   = r_pc;
                    w_state_d      = StFetch;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst_if) begin
        if (i_rst_if) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_pc_out     <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_req_addr   <= w_req_addr_d;
            r_drop       <= w_drop_d;
            r_inst_valid <= w_inst_valid_d;
            r_inst_out   <= w_inst_out_d;
            r_pc_out     <= w_pc_out_d;
            r_misalign   <= w_misalign_d;
        end
    end

    assign o_imem_req      = (r_state == StFetch);
    assign o_imem_addr     = r_req_addr;
    assign o_inst_valid    = r_inst_valid;
    assign o_inst_out      = r_inst_out;
    assign o_pc_out        = r_pc_out;
    assign o_addr_misalign = r_misalign;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, an imem responder with programmable latency,
// and a scoreboard whose monitor pops an expected {pc, inst} on every accepted instruction.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        branch = 1'b0;
    logic [31:0] target = '0;
    logic        ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] req_log[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          latency = 1;

    if_fetch_unit #(
        .BUS_WIDTH (32),
        .RESET_PC  (32'h0000_0000),
        .PC_STEP   (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_if        (rst),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .i_branch_taken  (branch),
        .i_branch_target (target),
        .i_inst_ready    (ready),
        .o_inst_valid    (inst_valid),
        .o_inst_out      (inst_out),
        .o_pc_out        (pc_out),
        .o_addr_misalign (misalign)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its address XOR a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        branch = 1'b0;
        ready  = 1'b0;
        rst    = 1'b1;
        cyc();
        cyc();
        req_log.delete();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!inst_valid && k < 50) begin
            cyc();
            k++;
        end
        if (!inst_valid) fail_now(name);
    endtask

    task automatic wait_acc(input int target_cnt, input string name);
        int k = 0;
        while (n_acc < target_cnt && k < 100) begin
            cyc();
            k++;
        end
        if (n_acc < target_cnt) fail_now(name);
    endtask

    task automatic check_log(input int idx, input logic [31:0] exp, input string name);
        if (req_log.size() <= idx) fail_now(name);
        else check(name, req_log[idx], exp);
    endtask

    // imem responder: latches a request, acks `latency` cycles later, drops it on reset.
    initial begin
        logic [31:0] lat_addr;
        int          cnt;
        bit          busy;
        busy = 1'b0;
        cnt  = 0;
        lat_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                check("imem_req held", {31'b0, imem_req}, 32'd1);
                check("imem_addr stable", imem_addr, lat_addr);
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(lat_addr);
                    busy       = 1'b0;
                end
            end else if (imem_req) begin
                busy     = 1'b1;
                lat_addr = imem_addr;
                cnt      = latency;
                req_log.push_back(imem_addr);
            end
        end
    end

    // Monitor: an instruction is consumed when valid & ready with no redirect in that cycle.
    always @(negedge clk) begin
        if (!rst && inst_valid && ready && !branch) begin
            n_acc++;
            if (sb_q.size() == 0) begin
                fail_now("unexpected instruction");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pc_out", pc_out, e.pc);
                check("inst_out", inst_out, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        int          k;

        // 1. Reset values, then sequential fetch with 1-cycle imem.
        cyc();
        check("rst imem_req", {31'b0, imem_req}, 32'd0);
        check("rst imem_addr", imem_addr, 32'h0);
        check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst inst_out", inst_out, 32'h0);
        check("rst pc_out", pc_out, 32'h0);
        check("rst misalign", {31'b0, misalign}, 32'd0);
        cyc();
        rst = 1'b0;
        expect_inst(32'h0);
        expect_inst(32'h4);
        expect_inst(32'h8);
        ready = 1'b1;
        wait_acc(3, "t1 accepts");
        ready = 1'b0;
        check_log(0, 32'h0, "t1 req0");
        check_log(1, 32'h4, "t1 req1");
        check_log(2, 32'h8, "t1 req2");

        // 2. Backpressure: held outputs stable, no request, then exactly one next request.
        wait_valid("t2 valid");
        h_inst = inst_out;
        h_pc   = pc_out;
        check("t2 held pc", h_pc, 32'hC);
        req_log.delete();
        repeat (5) begin
            cyc();
            check("t2 inst stable", inst_out, h_inst);
            check("t2 pc stable", pc_out, h_pc);
            check("t2 no req", {31'b0, imem_req}, 32'd0);
            check("t2 valid held", {31'b0, inst_valid}, 32'd1);
        end
        expect_inst(32'hC);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        wait_valid("t2 next valid");
        check("t2 req count", req_log.size(), 32'd1);
        check_log(0, 32'h10, "t2 next req");
        check("t2 next pc", pc_out, 32'h10);

        // 3. Redirect during a 3-cycle fetch: stale word must be dropped.
        latency = 3;
        do_reset();
        cyc();
        cyc();
        cyc();
        branch = 1'b1;
        target = 32'h100;
        cyc();
        branch = 1'b0;
        expect_inst(32'h100);
        ready = 1'b1;
        wait_acc(5, "t3 accept");
        ready = 1'b0;
        check_log(0, 32'h0, "t3 req0");
        check_log(1, 32'h100, "t3 req1");

        // 4. Redirect in the same cycle as the ack.
        latency = 1;
        do_reset();
        cyc();
        cyc();
        branch = 1'b1;
        target = 32'h40;
        cyc();
        branch = 1'b0;
        check("t4 valid low a", {31'b0, inst_valid}, 32'd0);
        cyc();
        check("t4 valid low b", {31'b0, inst_valid}, 32'd0);
        cyc();
        check("t4 valid high", {31'b0, inst_valid}, 32'd1);
        check("t4 pc_out", pc_out, 32'h40);
        expect_inst(32'h40);
        ready = 1'b1;
        wait_acc(6, "t4 accept");
        ready = 1'b0;
        check_log(1, 32'h40, "t4 req1");

        // 5. Misaligned redirect from HOLD, with ready high in the same cycle.
        do_reset();
        wait_valid("t5 valid");
        branch = 1'b1;
        target = 32'h102;
        ready  = 1'b1;
        cyc();
        branch = 1'b0;
        ready  = 1'b0;
        check("t5 misalign", {31'b0, misalign}, 32'd1);
        check("t5 squashed", {31'b0, inst_valid}, 32'd0);
        check("t5 req", {31'b0, imem_req}, 32'd1);
        check("t5 addr", imem_addr, 32'h100);
        cyc();
        check("t5 misalign pulse", {31'b0, misalign}, 32'd0);
        expect_inst(32'h100);
        ready = 1'b1;
        wait_acc(7, "t5 accept");
        ready = 1'b0;

        // 7. PC wraps from 0xFFFFFFFC to 0x0.
        wait_valid("t7 valid");
        branch = 1'b1;
        target = 32'hFFFF_FFFC;
        cyc();
        branch = 1'b0;
        check("t7 no misalign", {31'b0, misalign}, 32'd0);
        check("t7 addr", imem_addr, 32'hFFFF_FFFC);
        expect_inst(32'hFFFF_FFFC);
        expect_inst(32'h0);
        ready = 1'b1;
        wait_acc(9, "t7 accept");
        ready = 1'b0;

        // 6. Asynchronous reset in the middle of a fetch.
        do_reset();
        wait_valid("t6 valid");
        latency = 3;
        expect_inst(32'h0);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("t6 req", {31'b0, imem_req}, 32'd0);
        check("t6 valid", {31'b0, inst_valid}, 32'd0);
        check("t6 inst_out", inst_out, 32'h0);
        check("t6 pc_out", pc_out, 32'h0);
        cyc();
        cyc();
        req_log.delete();
        latency = 1;
        rst = 1'b0;
        k = 0;
        while (req_log.size() == 0 && k < 20) begin
            cyc();
            k++;
        end
        check_log(0, 32'h0, "t6 first req");
        expect_inst(32'h0);
        ready = 1'b1;
        wait_acc(11, "t6 accept");
        ready = 1'b0;

        cyc();
        check("scoreboard drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
